// File: rtl/layer_round_formatter_if.sv
// Activation stream from the round formatter to the next-layer buffer.
interface layer_round_formatter_if #(
   parameter int OUT_WIDTH = 8,
   parameter int LANES     = 8
);
   logic                     out_valid_o;
   logic                     out_ready_i;
   logic [OUT_WIDTH-1:0]     out_data_o;
   logic [$clog2(LANES)-1:0] out_lane_o;

   modport master (
      output out_valid_o,
      output out_data_o,
      output out_lane_o,
      input  out_ready_i
   );

   modport slave (
      input  out_valid_o,
      input  out_data_o,
      input  out_lane_o,
      output out_ready_i
   );
endinterface

// File: rtl/layer_round_formatter.sv
// Requantizes one row of PE accumulators into activations, one lane per cycle.
// Build option: ROUND_RELU_EN enables the ReLU clip driven by relu_i.
module layer_round_formatter #(
   parameter int ACC_WIDTH   = 20,
   parameter int OUT_WIDTH   = 8,
   parameter int LANES       = 8,
   parameter int SHIFT_WIDTH = 5
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start_i,
   input  logic [LANES*ACC_WIDTH-1:0]   acc_data_i,
   input  logic [SHIFT_WIDTH-1:0]       shift_i,
   input  logic                         relu_i,
   output logic                         busy_o,
   output logic                         done_o,
   output logic [$clog2(LANES+1)-1:0]   sat_cnt_o,
   layer_round_formatter_if.master      act
);
   localparam int AW = ACC_WIDTH;
   localparam int TW = ACC_WIDTH + 1;
   localparam int OW = OUT_WIDTH;
   localparam int SW = SHIFT_WIDTH;
   localparam int LW = $clog2(LANES);
   localparam int CW = $clog2(LANES + 1);

   localparam logic signed [TW-1:0] MAXV = TW'((2 ** (OW - 1)) - 1);
   localparam logic signed [TW-1:0] MINV = ~MAXV;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t               state;
   logic [LANES*AW-1:0]  acc_q;
   logic [SW-1:0]        shift_q;
   logic [CW-1:0]        icnt;

`ifdef ROUND_RELU_EN
   logic                 relu_q;
`else
   logic                 unused_relu;
   assign unused_relu = relu_i;
`endif

   logic                 advance;
   logic                 fire;
   logic                 issuing;
   logic                 last;

   assign advance = !act.out_valid_o || act.out_ready_i;
   assign fire    = act.out_valid_o && act.out_ready_i;
   assign issuing = (icnt != CW'(LANES));
   assign last    = (act.out_lane_o == LW'(LANES - 1));

   // Stage A: lane select, shift clamp, round-half-up shift
   logic signed [AW-1:0] acc_sel;
   logic [SW-1:0]        s;
   logic [TW-1:0]        rnd;
   logic signed [TW-1:0] t;

   always_comb begin
      acc_sel = acc_q[icnt[LW-1:0]*AW +: AW];
      s = (shift_q > SW'(AW - 1)) ? SW'(AW - 1) : shift_q;
      rnd = '0;
      if (s != '0)
         rnd = TW'(1) << (s - 1'b1);
      t = ($signed({acc_sel[AW-1], acc_sel}) + $signed(rnd)) >>> s;
   end

   // Stage B: saturate, optional ReLU
   logic          pos_clip;
   logic          neg_clip;
   logic          sat_hit;
   logic [OW-1:0] y;

   always_comb begin
      pos_clip = (t > MAXV);
      neg_clip = (t < MINV);
      y = t[OW-1:0];
      if (pos_clip)
         y = MAXV[OW-1:0];
      else if (neg_clip)
         y = MINV[OW-1:0];
`ifdef ROUND_RELU_EN
      // a negative clip that ReLU zeroes is not reported as saturation
      if (relu_q && y[OW-1])
         y = '0;
      sat_hit = pos_clip || (neg_clip && !relu_q);
`else
      sat_hit = pos_clip || neg_clip;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         busy_o          <= 1'b0;
         done_o          <= 1'b0;
         sat_cnt_o       <= '0;
         icnt            <= '0;
         acc_q           <= '0;
         shift_q         <= '0;
`ifdef ROUND_RELU_EN
         relu_q          <= 1'b0;
`endif
         act.out_valid_o <= 1'b0;
         act.out_data_o  <= '0;
         act.out_lane_o  <= '0;
      end else begin
         done_o <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start_i) begin
                  acc_q     <= acc_data_i;
                  shift_q   <= shift_i;
`ifdef ROUND_RELU_EN
                  relu_q    <= relu_i;
`endif
                  icnt      <= '0;
                  sat_cnt_o <= '0;
                  busy_o    <= 1'b1;
                  state     <= RUN;
               end
            end
            RUN: begin
               if (advance) begin
                  if (issuing) begin
                     act.out_data_o  <= y;
                     act.out_lane_o  <= icnt[LW-1:0];
                     act.out_valid_o <= 1'b1;
                     icnt            <= icnt + 1'b1;
                     if (sat_hit)
                        sat_cnt_o <= sat_cnt_o + 1'b1;
                  end else begin
                     act.out_valid_o <= 1'b0;
                  end
               end
               if (fire && last) begin
                  done_o <= 1'b1;
                  state  <= DONE;
               end
            end
            DONE: begin
               busy_o <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_layer_round_formatter.sv
// Bench for layer_round_formatter: table vectors, corner sequences, backpressure.
module tb_layer_round_formatter;
   localparam int LANES = 8;
   localparam int AW    = 20;
   localparam int OW    = 8;
   localparam int SW    = 5;
   localparam int LW    = $clog2(LANES);
   localparam int CW    = $clog2(LANES + 1);

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                start_i = 1'b0;
   logic [LANES*AW-1:0] acc_data_i = '0;
   logic [SW-1:0]       shift_i = '0;
   logic                relu_i = 1'b0;
   logic                busy_o;
   logic                done_o;
   logic [CW-1:0]       sat_cnt_o;

   layer_round_formatter_if #(.OUT_WIDTH(OW), .LANES(LANES)) act_if ();

   layer_round_formatter #(
      .ACC_WIDTH(AW), .OUT_WIDTH(OW), .LANES(LANES), .SHIFT_WIDTH(SW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .start_i(start_i),
      .acc_data_i(acc_data_i),
      .shift_i(shift_i),
      .relu_i(relu_i),
      .busy_o(busy_o),
      .done_o(done_o),
      .sat_cnt_o(sat_cnt_o),
      .act(act_if)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int total = 0;
   int bad = 0;

   typedef struct {
      int lane;
      int data;
   } exp_t;

   typedef struct {
      int acc[LANES];
      int sh;
      bit relu;
      int exp[LANES];
      int sat;
   } vec_t;

   exp_t sb[$];
   int   sat_q[$];
   int   done_cnt = 0;
   int   done_cyc = 0;
   int   c0 = 0;
   int   exp_done = 0;
   int   hs_cyc[LANES];
   bit   ready_rand = 1'b0;

   task automatic check(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [LANES*AW-1:0] pack(input int a[LANES]);
      logic [LANES*AW-1:0] v;
      v = '0;
      for (int i = 0; i < LANES; i++)
         v[i*AW +: AW] = a[i][AW-1:0];
      return v;
   endfunction

   function automatic void model(input int a[LANES], input int sh, input bit relu,
                                 output int e[LANES], output int sat);
      int s;
      longint t;
      bit relu_eff;
`ifdef ROUND_RELU_EN
      relu_eff = relu;
`else
      relu_eff = 1'b0;
`endif
      s = (sh > AW - 1) ? AW - 1 : sh;
      sat = 0;
      for (int i = 0; i < LANES; i++) begin
         t = a[i];
         if (s > 0)
            t = t + (longint'(1) << (s - 1));
         t = t >>> s;
         if (t > 127) begin
            e[i] = 127;
            sat++;
         end else if (t < -128) begin
            e[i] = relu_eff ? 0 : -128;
            if (!relu_eff)
               sat++;
         end else begin
            e[i] = (relu_eff && t < 0) ? 0 : int'(t);
         end
      end
   endfunction

   // ready driver
   initial begin
      act_if.out_ready_i = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         act_if.out_ready_i = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // output monitor / scoreboard
   bit            pstall = 1'b0;
   logic [OW-1:0] pdata;
   logic [LW-1:0] plane;

   initial begin
      exp_t e;
      int   s;
      forever begin
         @(negedge clk);
         if (rst) begin
            pstall = 1'b0;
         end else begin
            if (pstall) begin
               check("stall_valid", act_if.out_valid_o, 1);
               check("stall_data", act_if.out_data_o, pdata);
               check("stall_lane", act_if.out_lane_o, plane);
            end
            if (act_if.out_valid_o && act_if.out_ready_i) begin
               if (sb.size() == 0) begin
                  check("extra_lane", act_if.out_lane_o, -1);
               end else begin
                  e = sb.pop_front();
                  check("lane", act_if.out_lane_o, e.lane);
                  check("data", $signed(act_if.out_data_o), e.data);
                  hs_cyc[act_if.out_lane_o] = cyc;
               end
            end
            if (done_o) begin
               done_cnt++;
               done_cyc = cyc;
               if (sat_q.size() == 0) begin
                  check("extra_done", 1, 0);
               end else begin
                  s = sat_q.pop_front();
                  check("sat_cnt", sat_cnt_o, s);
               end
               check("done_sb_empty", sb.size(), 0);
            end
            pstall = act_if.out_valid_o && !act_if.out_ready_i;
            pdata  = act_if.out_data_o;
            plane  = act_if.out_lane_o;
         end
      end
   end

   task automatic go(input int a[LANES], input int sh, input bit relu,
                     input int e[LANES], input int sat);
      int   n;
      exp_t x;
      n = 0;
      while (busy_o && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (busy_o)
         check("idle_timeout", busy_o, 0);
      for (int i = 0; i < LANES; i++) begin
         x.lane = i;
         x.data = e[i];
         sb.push_back(x);
      end
      sat_q.push_back(sat);
      acc_data_i = pack(a);
      shift_i    = SW'(sh);
      relu_i     = relu;
      start_i    = 1'b1;
      c0         = cyc;
      @(negedge clk);
      start_i = 1'b0;
      check("busy_c1", busy_o, 1);
   endtask

   task automatic wait_done(input int target);
      int n;
      n = 0;
      while (done_cnt < target && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (done_cnt < target)
         check("done_timeout", done_cnt, target);
   endtask

   vec_t tv[6];

   initial begin
      int a[LANES];
      int e[LANES];
      int sat;
      int n;
      int base;

      tv[0].acc = '{384, 392, -392, 0, 8, -8, 24, -24};
      tv[0].sh = 4; tv[0].relu = 0; tv[0].sat = 0;
      tv[0].exp = '{24, 25, -24, 0, 1, 0, 2, -1};
      tv[1].acc = '{524287, -524288, 0, 0, 0, 0, 0, 0};
      tv[1].sh = 4; tv[1].relu = 0; tv[1].sat = 2;
      tv[1].exp = '{127, -128, 0, 0, 0, 0, 0, 0};
      tv[2].acc = '{5, 0, 0, 0, 0, 0, 0, 0};
      tv[2].sh = 0; tv[2].relu = 0; tv[2].sat = 0;
      tv[2].exp = '{5, 0, 0, 0, 0, 0, 0, 0};
      tv[3].acc = '{-1, 0, 0, 0, 0, 0, 0, 0};
      tv[3].sh = 31; tv[3].relu = 0; tv[3].sat = 0;
      tv[3].exp = '{0, 0, 0, 0, 0, 0, 0, 0};
      tv[4].acc = '{-392, 392, 0, 0, 0, 0, 0, 0};
      tv[4].sh = 4; tv[4].relu = 1; tv[4].sat = 0;
`ifdef ROUND_RELU_EN
      tv[4].exp = '{0, 25, 0, 0, 0, 0, 0, 0};
`else
      tv[4].exp = '{-24, 25, 0, 0, 0, 0, 0, 0};
`endif
      tv[5].acc = '{200, -200, 127, -128, 128, -129, 0, 0};
      tv[5].sh = 0; tv[5].relu = 0; tv[5].sat = 4;
      tv[5].exp = '{127, -128, 127, -128, 127, -128, 0, 0};

      // reset state
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_busy", busy_o, 0);
      check("rst_valid", act_if.out_valid_o, 0);
      check("rst_done", done_o, 0);
      check("rst_data", act_if.out_data_o, 0);
      check("rst_lane", act_if.out_lane_o, 0);
      check("rst_sat", sat_cnt_o, 0);
      rst = 1'b0;
      @(negedge clk);

      // table vectors, ready held high
      for (int k = 0; k < 6; k++) begin
         go(tv[k].acc, tv[k].sh, tv[k].relu, tv[k].exp, tv[k].sat);
         exp_done++;
         wait_done(exp_done);
         for (int l = 0; l < LANES; l++)
            check("lane_cycle", hs_cyc[l], c0 + 2 + l);
         check("done_cycle", done_cyc, c0 + LANES + 2);
         check("sat_hold", sat_cnt_o, tv[k].sat);
      end

      // start pulsed mid-round is ignored
      go(tv[0].acc, tv[0].sh, tv[0].relu, tv[0].exp, tv[0].sat);
      exp_done++;
      repeat (3) @(negedge clk);
      for (int i = 0; i < LANES; i++) a[i] = 1000;
      acc_data_i = pack(a);
      shift_i = '0;
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      wait_done(exp_done);

      // reset while lane 3 is on the output
      go(tv[1].acc, tv[1].sh, tv[1].relu, tv[1].exp, tv[1].sat);
      n = 0;
      while (!(act_if.out_valid_o && act_if.out_lane_o == LW'(3)) && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("lane3_seen", act_if.out_lane_o, 3);
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid_valid", act_if.out_valid_o, 0);
      check("rst_mid_busy", busy_o, 0);
      check("rst_mid_done", done_o, 0);
      sb.delete();
      sat_q.delete();
      rst = 1'b0;
      base = done_cnt;
      repeat (5) @(negedge clk);
      check("rst_no_done", done_cnt, base);
      go(tv[0].acc, tv[0].sh, tv[0].relu, tv[0].exp, tv[0].sat);
      exp_done++;
      wait_done(exp_done);
      check("post_rst_done_cycle", done_cyc, c0 + LANES + 2);

      // random backpressure
      ready_rand = 1'b1;
      for (int r = 0; r < 100; r++) begin
         for (int i = 0; i < LANES; i++)
            a[i] = int'($urandom_range(0, (1 << AW) - 1)) - (1 << (AW - 1));
         n = int'($urandom_range(0, 31));
         model(a, n, 1'b0, e, sat);
         go(a, n, 1'b0, e, sat);
         exp_done++;
         wait_done(exp_done);
      end
      ready_rand = 1'b0;
      repeat (4) @(negedge clk);

      check("done_count", done_cnt, exp_done);
      check("sb_left", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end
endmodule
